// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ write-domain requesters.
// One owner at a time for up to MAX_BURST accepted words; writes are gated by the FIFO full flag.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                     w_clk,
  input  logic                     w_rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic                     full,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     w_en,
  output logic [WIDTH-1:0]         data_in,
  output logic                     busy
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam int unsigned PtrW = $clog2(NUM_REQ);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e            state_q;
  logic [CntW-1:0]   count_q;
  logic [PtrW-1:0]   ptr_q;

  logic              owner_req;
  logic              wr;
  logic              term;
  logic              found;
  logic [PtrW-1:0]   winner;
  logic [PtrW-1:0]   idx;
  logic [NUM_REQ-1:0] winner_oh;

  // While a burst is active ptr_q is the owner, so it also selects the data slice.
  assign owner_req = req[ptr_q];
  assign wr        = (|(gnt & req)) & ~full;
  assign w_en      = wr;
  assign ack       = gnt & req & {NUM_REQ{~full}};
  assign data_in   = (|gnt) ? req_data[32'(ptr_q) * WIDTH +: WIDTH] : '0;

  // A stall never ends a burst; only the last word or a dropped owner request does.
  assign term = (wr && (count_q == CntW'(MAX_BURST - 1))) || !owner_req;

  // Search upward from ptr_q+1 with wrap; the last slot visited is the current owner.
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    idx    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = PtrW'((32'(ptr_q) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign winner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state_q <= StIdle;
      gnt     <= '0;
      busy    <= 1'b0;
      count_q <= '0;
      ptr_q   <= PtrW'(NUM_REQ - 1);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (found) begin
            state_q <= StBurst;
            gnt     <= winner_oh;
            busy    <= 1'b1;
            count_q <= '0;
            ptr_q   <= winner;
          end
        end
        StBurst: begin
          if (term) begin
            count_q <= '0;
            if (found) begin
              gnt   <= winner_oh;
              ptr_q <= winner;
            end else begin
              state_q <= StIdle;
              gnt     <= '0;
              busy    <= 1'b0;
            end
          end else if (wr) begin
            count_q <= count_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          gnt     <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle vector table plus hand-written reset and
// MAX_BURST=1 sequences, with invariant checks on both instances every cycle.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int W  = 8;

  typedef struct {
    int         test;
    logic       rst_before;
    logic [3:0] req;
    logic       full;
    logic [3:0] gnt;
    logic [3:0] ack;
    logic       wen;
    logic [7:0] data;
    logic       busy;
  } vec_t;

  logic            w_clk;
  logic            w_rst;
  logic [NR-1:0]   req;
  logic [NR*W-1:0] req_data;
  logic            full;
  logic [NR-1:0]   gnt, ack, gnt1, ack1;
  logic            w_en, busy, w_en1, busy1;
  logic [W-1:0]    data_in, data_in1;

  int tests;
  int fails;
  vec_t vecs[$];

  fifo_wr_arbiter #(.NUM_REQ(NR), .WIDTH(W), .MAX_BURST(4)) dut (
    .w_clk(w_clk), .w_rst(w_rst), .req(req), .req_data(req_data), .full(full),
    .gnt(gnt), .ack(ack), .w_en(w_en), .data_in(data_in), .busy(busy)
  );

  fifo_wr_arbiter #(.NUM_REQ(NR), .WIDTH(W), .MAX_BURST(1)) dut1 (
    .w_clk(w_clk), .w_rst(w_rst), .req(req), .req_data(req_data), .full(full),
    .gnt(gnt1), .ack(ack1), .w_en(w_en1), .data_in(data_in1), .busy(busy1)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic inv(input string tag, input logic [3:0] g, input logic [3:0] a,
                     input logic [3:0] r, input logic we, input logic f, input int maxb,
                     inout int run, inout logic [3:0] own);
    chk({tag, " gnt onehot0"}, 32'($countones(g) <= 1), 32'd1);
    chk({tag, " wen&full"}, 32'(we & f), 32'd0);
    chk({tag, " ack onehot0"}, 32'($countones(a) <= 1), 32'd1);
    chk({tag, " ack in gnt"}, 32'(a & ~g), 32'd0);
    if (g != own) run = 0;
    own = g;
    if (we) begin
      if ((r & ~g) != 0) run++;
      else run = 0;
    end
    chk({tag, " burst bound"}, 32'(run <= maxb), 32'd1);
  endtask

  int         run0, run1;
  logic [3:0] own0, own1;

  always @(negedge w_clk) begin
    inv("dut", gnt, ack, req, w_en, full, 4, run0, own0);
    inv("dut1", gnt1, ack1, req, w_en1, full, 1, run1, own1);
  end

  task automatic add(input int t, input logic rb, input logic [3:0] r, input logic f,
                     input logic [3:0] g, input logic [3:0] a, input logic we,
                     input logic [7:0] d, input logic b);
    vec_t v;
    v.test = t; v.rst_before = rb; v.req = r; v.full = f;
    v.gnt = g; v.ack = a; v.wen = we; v.data = d; v.busy = b;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    w_rst = 1'b1;
    req   = '0;
    full  = 1'b0;
    @(negedge w_clk);
    w_rst = 1'b0;
    @(posedge w_clk);
    #1;
  endtask

  initial begin
    logic [3:0] e;
    tests = 0; fails = 0; run0 = 0; run1 = 0; own0 = '0; own1 = '0;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};

    // 1: single requester, 6 words, re-grant to itself at word 4 with no gap
    add(1, 0, 4'b0100, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);
    for (int i = 0; i < 6; i++) add(1, 0, 4'b0100, 0, 4'b0100, 4'b0100, 1, 8'h12, 1);
    add(1, 0, 4'b0000, 0, 4'b0100, 4'b0000, 0, 8'h12, 1);
    add(1, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);
    // 2: all requesting, order 0,1,2,3,0 with 4 words each
    add(2, 1, 4'b1111, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);
    for (int o = 0; o < 4; o++)
      for (int i = 0; i < 4; i++)
        add(2, 0, 4'b1111, 0, 4'(1 << o), 4'(1 << o), 1, 8'(8'h10 + o), 1);
    add(2, 0, 4'b1111, 0, 4'b0001, 4'b0001, 1, 8'h10, 1);
    add(2, 0, 4'b0000, 0, 4'b0001, 4'b0000, 0, 8'h10, 1);
    add(2, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);
    // 3: full stall after word 2 holds grant and count; req[3] joins on the last word
    add(3, 1, 4'b0010, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);
    for (int i = 0; i < 2; i++) add(3, 0, 4'b0010, 0, 4'b0010, 4'b0010, 1, 8'h11, 1);
    for (int i = 0; i < 3; i++) add(3, 0, 4'b0010, 1, 4'b0010, 4'b0000, 0, 8'h11, 1);
    add(3, 0, 4'b0010, 0, 4'b0010, 4'b0010, 1, 8'h11, 1);
    add(3, 0, 4'b1010, 0, 4'b0010, 4'b0010, 1, 8'h11, 1);
    add(3, 0, 4'b1000, 0, 4'b1000, 4'b1000, 1, 8'h13, 1);
    add(3, 0, 4'b0000, 0, 4'b1000, 4'b0000, 0, 8'h13, 1);
    add(3, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);
    // 4: owner drops after 2 words, handoff to 3 without leaving BURST
    add(4, 1, 4'b0010, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);
    for (int i = 0; i < 2; i++) add(4, 0, 4'b1010, 0, 4'b0010, 4'b0010, 1, 8'h11, 1);
    add(4, 0, 4'b1000, 0, 4'b0010, 4'b0000, 0, 8'h11, 1);
    add(4, 0, 4'b1000, 0, 4'b1000, 4'b1000, 1, 8'h13, 1);
    add(4, 0, 4'b0000, 0, 4'b1000, 4'b0000, 0, 8'h13, 1);
    add(4, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);

    // Reset state
    w_rst = 1'b1; req = '0; full = 1'b0;
    @(negedge w_clk);
    chk("reset gnt", 32'(gnt), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset w_en", 32'(w_en), 32'd0);
    chk("reset ack", 32'(ack), 32'd0);
    chk("reset data_in", 32'(data_in), 32'd0);
    w_rst = 1'b0;
    @(posedge w_clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst_before) do_reset();
      req  = vecs[i].req;
      full = vecs[i].full;
      @(negedge w_clk);
      chk($sformatf("t%0d v%0d gnt", vecs[i].test, i), 32'(gnt), 32'(vecs[i].gnt));
      chk($sformatf("t%0d v%0d ack", vecs[i].test, i), 32'(ack), 32'(vecs[i].ack));
      chk($sformatf("t%0d v%0d w_en", vecs[i].test, i), 32'(w_en), 32'(vecs[i].wen));
      chk($sformatf("t%0d v%0d data_in", vecs[i].test, i), 32'(data_in), 32'(vecs[i].data));
      chk($sformatf("t%0d v%0d busy", vecs[i].test, i), 32'(busy), 32'(vecs[i].busy));
      @(posedge w_clk);
      #1;
    end

    // 5: asynchronous reset mid-burst, then requester 0 wins first
    do_reset();
    req = 4'b0100;
    @(posedge w_clk);
    #1;
    @(negedge w_clk);
    chk("t5 pre gnt", 32'(gnt), 32'b0100);
    chk("t5 pre w_en", 32'(w_en), 32'd1);
    #2;
    w_rst = 1'b1;
    #1;
    chk("t5 async gnt", 32'(gnt), 32'd0);
    chk("t5 async w_en", 32'(w_en), 32'd0);
    chk("t5 async ack", 32'(ack), 32'd0);
    chk("t5 async busy", 32'(busy), 32'd0);
    req = 4'b1001;
    @(negedge w_clk);
    w_rst = 1'b0;
    @(posedge w_clk);
    #1;
    chk("t5 regrant gnt", 32'(gnt), 32'b0001);
    chk("t5 regrant busy", 32'(busy), 32'd1);
    chk("t5 regrant data_in", 32'(data_in), 32'h10);

    // 6: MAX_BURST=1 instance rotates every cycle
    do_reset();
    req = 4'b1111;
    @(negedge w_clk);
    chk("t6 idle gnt", 32'(gnt1), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(posedge w_clk);
      #1;
      @(negedge w_clk);
      e = 4'b0001 << (k % 4);
      chk($sformatf("t6 c%0d gnt", k), 32'(gnt1), 32'(e));
      chk($sformatf("t6 c%0d ack", k), 32'(ack1), 32'(e));
      chk($sformatf("t6 c%0d w_en", k), 32'(w_en1), 32'd1);
    end
    req = '0;
    @(posedge w_clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
